// File: rtl/chunk_adder_pkg.sv
// Shared constants and types for the chunk-serial adder.
package chunk_adder_pkg;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_NUM_CHUNKS = 4;
  localparam int unsigned DEF_IDX_W      = $clog2(DEF_NUM_CHUNKS);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/chunk_serial_adder_if.sv
// Operand-in / sum-out valid-ready streams of the chunk-serial adder.
interface chunk_serial_adder_if #(
  parameter int unsigned WIDTH = chunk_adder_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_last;
  logic             out_cout;

  // Adder side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout
  );

  // Source/consumer side
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout
  );
endinterface

// File: rtl/adder_slice.sv
// Combinational WIDTH-bit adder slice; port order matches the ripple full-adder chain.
module adder_slice #(
  parameter int unsigned WIDTH = chunk_adder_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned SW = WIDTH + 1;

  assign {cout, sum} = SW'(a) + SW'(b) + SW'(cin);
endmodule

// File: rtl/chunk_serial_adder.sv
// Wide adder built from one WIDTH-bit slice, one chunk per beat, LSB chunk first,
// with a registered carry chain and a single registered output stage.
module chunk_serial_adder
  import chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned NUM_CHUNKS = DEF_NUM_CHUNKS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunk_serial_adder_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             last_q, last_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             cin_sel;
  logic             is_last;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;

  // No skid buffer: accept only when the output register is free or draining.
  assign bus.in_ready = !valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  // Chunk 0 always takes the word carry-in, so carry_q never crosses words.
  assign cin_sel      = (state_q == IDLE) ? bus.in_cin : carry_q;
  assign is_last      = (idx_q == LAST_IDX);

  adder_slice #(.WIDTH(WIDTH)) u_slice (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .cin  (cin_sel),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state, counter, carry and output-register update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;

    if (accept) begin
      carry_d = slice_cout;
      sum_d   = slice_sum;
      last_d  = is_last;
      cout_d  = is_last & slice_cout;
      valid_d = 1'b1;
      if (is_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        state_d = ACCUM;
        idx_d   = idx_q + IDX_W'(1);
      end
    end else if (bus.out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_last  = last_q;
  assign bus.out_cout  = cout_q;
endmodule
